// File: rtl/mem_bus_pkg.sv
// Shared definitions for native-memory-bus peripherals: register offsets,
// control bit positions, responder FSM state codes and a byte-merge helper.
package mem_bus_pkg;

    // Byte offsets of the timer registers (addr[1:0] are ignored by decode).
    localparam logic [31:0] REG_COUNT    = 32'h0000_0000;
    localparam logic [31:0] REG_COMPARE  = 32'h0000_0004;
    localparam logic [31:0] REG_CTRL     = 32'h0000_0008;
    localparam logic [31:0] REG_STATUS   = 32'h0000_000C;
    localparam logic [31:0] REG_PRESCALE = 32'h0000_0010;
    localparam logic [31:0] REG_ID       = 32'h0000_0014;

    // CTRL register bit positions.
    localparam int CTRL_EN           = 0;
    localparam int CTRL_CLR_ON_MATCH = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int CTRL_WIDTH        = 3;

    // A transaction with no byte enables is a read.
    localparam logic [3:0] WSTRB_READ = 4'b0000;

    // Handshake FSM state codes, kept as plain constants for older tools.
    typedef logic [1:0] bus_state_t;
    localparam bus_state_t ST_IDLE    = 2'd0;
    localparam bus_state_t ST_ACCESS  = 2'd1;
    localparam bus_state_t ST_ACK     = 2'd2;
    localparam bus_state_t ST_RELEASE = 2'd3;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_value;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_value[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_timer_responder_if.sv
// picorv32-style native memory bus seen by a single responder.
interface mem_timer_responder_if;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    // Initiator side: issues requests, receives completion and read data.
    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    // Responder side: the peripheral answering the request.
    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bus_responder_fsm.sv
// Generic request/acknowledge handshake for native-bus responders.
// Produces a one-cycle access strobe, a one-cycle ready pulse, and waits
// for the initiator to drop mem_valid before accepting another request.
module mem_bus_responder_fsm
    import mem_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_valid,
    input  logic [3:0] mem_wstrb,
    output logic       access,
    output logic       is_write,
    output logic       mem_ready
);

    bus_state_t state_q;

    // Handshake sequencing: IDLE -> ACCESS -> ACK -> RELEASE -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (mem_valid) state_q <= ST_ACCESS;
                ST_ACCESS:  state_q <= ST_ACK;
                ST_ACK:     state_q <= ST_RELEASE;
                ST_RELEASE: if (!mem_valid) state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Decoded from the state register so reset removes ready immediately.
    assign access    = (state_q == ST_ACCESS);
    assign mem_ready = (state_q == ST_ACK);
    assign is_write  = (mem_wstrb != WSTRB_READ);

endmodule

// File: rtl/mem_timer_responder.sv
// Memory-mapped prescaled 32-bit timer with compare match, sticky status
// flag and registered level interrupt, answering on the native memory bus.
module mem_timer_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 8,
    parameter logic [31:0] ID_VALUE    = 32'h5449_4D31,
    parameter logic [31:0] RESET_COUNT = 32'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_timer_responder_if.slave  bus,
    output logic                  irq
);

    logic                  access;
    logic                  is_write;
    logic [31:0]           reg_off;
    logic [31:0]           read_value;
    logic                  wr_en;
    logic                  wr_count;
    logic                  wr_compare;
    logic                  wr_ctrl;
    logic                  wr_status;
    logic                  wr_prescale;
    logic                  tick;
    logic                  at_compare;
    logic                  match_set;
    logic                  match_clr;
    logic                  unused_addr_bits;

    logic [31:0]           count_q;
    logic [31:0]           compare_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic                  match_q;
    logic [31:0]           prescale_q;
    logic [31:0]           pcnt_q;
    logic [31:0]           rdata_q;
    logic                  irq_q;

    mem_bus_responder_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (bus.mem_valid),
        .mem_wstrb (bus.mem_wstrb),
        .access    (access),
        .is_write  (is_write),
        .mem_ready (bus.mem_ready)
    );

    // Word-aligned register offset from the low address bits only.
    assign reg_off = {{(32-ADDR_BITS){1'b0}}, bus.mem_addr[ADDR_BITS-1:2], 2'b00};
    assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_BITS], bus.mem_addr[1:0]};

    assign wr_en       = access && is_write;
    assign wr_count    = wr_en && (reg_off == REG_COUNT);
    assign wr_compare  = wr_en && (reg_off == REG_COMPARE);
    assign wr_ctrl     = wr_en && (reg_off == REG_CTRL);
    assign wr_status   = wr_en && (reg_off == REG_STATUS);
    assign wr_prescale = wr_en && (reg_off == REG_PRESCALE);

    assign tick       = ctrl_q[CTRL_EN] && (pcnt_q == prescale_q);
    assign at_compare = (count_q == compare_q);
    assign match_set  = tick && at_compare;
    assign match_clr  = wr_status && bus.mem_wstrb[0] && bus.mem_wdata[0];

    // Read multiplexer; undecoded offsets read as zero.
    always_comb begin
        read_value = 32'h0;
        case (reg_off)
            REG_COUNT:    read_value = count_q;
            REG_COMPARE:  read_value = compare_q;
            REG_CTRL:     read_value = {{(32-CTRL_WIDTH){1'b0}}, ctrl_q};
            REG_STATUS:   read_value = {31'h0, match_q};
            REG_PRESCALE: read_value = prescale_q;
            REG_ID:       read_value = ID_VALUE;
            default:      read_value = 32'h0;
        endcase
    end

    // Prescaler: wraps at PRESCALE, restarts whenever PRESCALE is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= 32'h0;
        end else if (wr_prescale) begin
            pcnt_q <= 32'h0;
        end else if (ctrl_q[CTRL_EN]) begin
            pcnt_q <= tick ? 32'h0 : pcnt_q + 32'd1;
        end
    end

    // Main counter: a bus write overrides the tick in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_COUNT;
        end else if (wr_count) begin
            count_q <= merge_bytes(count_q, bus.mem_wdata, bus.mem_wstrb);
        end else if (tick) begin
            count_q <= (at_compare && ctrl_q[CTRL_CLR_ON_MATCH]) ? 32'h0 : count_q + 32'd1;
        end
    end

    // Compare value register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare_q <= 32'hFFFF_FFFF;
        end else if (wr_compare) begin
            compare_q <= merge_bytes(compare_q, bus.mem_wdata, bus.mem_wstrb);
        end
    end

    // Control bits all live in byte lane 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else if (wr_ctrl && bus.mem_wstrb[0]) begin
            ctrl_q <= bus.mem_wdata[CTRL_WIDTH-1:0];
        end
    end

    // Sticky match flag; a new match beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else if (match_set) begin
            match_q <= 1'b1;
        end else if (match_clr) begin
            match_q <= 1'b0;
        end
    end

    // Prescale reload value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= 32'h0;
        end else if (wr_prescale) begin
            prescale_q <= merge_bytes(prescale_q, bus.mem_wdata, bus.mem_wstrb);
        end
    end

    // Read data is captured during ACCESS and held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0;
        end else if (access && !is_write) begin
            rdata_q <= read_value;
        end
    end

    // Interrupt is registered one cycle behind STATUS and CTRL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= match_q && ctrl_q[CTRL_IRQ_EN];
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_mem_timer_responder.sv
// Testbench for mem_timer_responder: constant vector table, hand-built
// corner sequences and randomized traffic against a cycle-level model.
module tb_mem_timer_responder;
    import mem_bus_pkg::*;

    logic clk;
    logic reset;
    logic irq;

    mem_timer_responder_if bus ();

    mem_timer_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model state.
    logic [31:0] m_count, m_compare, m_prescale, m_pcnt, m_rdata;
    logic [2:0]  m_ctrl;
    logic        m_match, m_irq;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_true(input string name, input bit ok, input logic [31:0] act);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got %h, outside required condition at %0t", name, act, $time);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_count = 32'd0; m_compare = 32'hFFFF_FFFF; m_prescale = 32'd0;
        m_pcnt = 32'd0; m_rdata = 32'd0; m_ctrl = 3'd0; m_match = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [7:0] off;
        off = a[7:0] & 8'hFC;
        case (off)
            8'h00:   return m_count;
            8'h04:   return m_compare;
            8'h08:   return {29'd0, m_ctrl};
            8'h0C:   return {31'd0, m_match};
            8'h10:   return m_prescale;
            8'h14:   return 32'h5449_4D31;
            default: return 32'd0;
        endcase
    endfunction

    // One rising edge of the behavioural timer; wr marks the edge a write lands on.
    task automatic model_edge(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        logic [7:0]  off;
        bit          tck, hit;
        logic [31:0] n_count, n_compare, n_prescale, n_pcnt;
        logic [2:0]  n_ctrl;
        logic        n_match, n_irq;
        off  = a[7:0] & 8'hFC;
        tck  = m_ctrl[0] && (m_pcnt == m_prescale);
        hit  = tck && (m_count == m_compare);
        n_irq = m_match & m_ctrl[2];
        n_count = m_count; n_compare = m_compare; n_prescale = m_prescale;
        n_pcnt = m_pcnt; n_ctrl = m_ctrl; n_match = m_match;
        if (m_ctrl[0]) n_pcnt = tck ? 32'd0 : m_pcnt + 32'd1;
        if (tck) n_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
        if (wr) begin
            case (off)
                8'h00: n_count = lane_merge(m_count, d, s);
                8'h04: n_compare = lane_merge(m_compare, d, s);
                8'h08: if (s[0]) n_ctrl = d[2:0];
                8'h0C: if (s[0] && d[0]) n_match = 1'b0;
                8'h10: begin
                    n_prescale = lane_merge(m_prescale, d, s);
                    n_pcnt = 32'd0;
                end
                default: ;
            endcase
        end
        if (hit) n_match = 1'b1;
        m_count = n_count; m_compare = n_compare; m_prescale = n_prescale;
        m_pcnt = n_pcnt; m_ctrl = n_ctrl; m_match = n_match; m_irq = n_irq;
    endtask

    task automatic step(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(wr, a, d, s);
        #1;
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    // Full transaction: request, ready pulse, then release of mem_valid.
    task automatic bus_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd);
        logic [31:0] exp_rd;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wstrb = wr ? s : WSTRB_READ;
        step(1'b0, a, d, s);
        exp_rd = m_read(a);
        step(wr, a, d, s);
        chk("ready_pulse", {31'd0, bus.mem_ready}, 32'd1);
        if (!wr) m_rdata = exp_rd;
        chk("rdata", bus.mem_rdata, m_rdata);
        rd = bus.mem_rdata;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = WSTRB_READ;
        step(1'b0, 32'd0, 32'd0, 4'd0);
        chk("ready_drop", {31'd0, bus.mem_ready}, 32'd0);
        step(1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        bus_xfer(1'b1, a, d, 4'hF, unused_rd);
    endtask

    task automatic applyStimulus();
        logic [31:0] rd, rd2, r, a, d;
        logic [7:0]  off;
        logic [3:0]  s;
        bit          wr;
        int          pulses;

        // Constant vector table, timer disabled so values are static.
        vecs[0]  = '{0, 32'h14, 32'h0, 4'h0, 32'h5449_4D31};
        vecs[1]  = '{0, 32'h18, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{0, 32'h04, 32'h0, 4'h0, 32'hFFFF_FFFF};
        vecs[3]  = '{1, 32'h04, 32'hAABB_CCDD, 4'b0101, 32'h0};
        vecs[4]  = '{0, 32'h04, 32'h0, 4'h0, 32'hFFBB_FFDD};
        vecs[5]  = '{1, 32'h08, 32'hFFFF_FFF8, 4'hF, 32'h0};
        vecs[6]  = '{0, 32'h08, 32'h0, 4'h0, 32'h0};
        vecs[7]  = '{1, 32'h14, 32'h1234_5678, 4'hF, 32'h0};
        vecs[8]  = '{0, 32'h16, 32'h0, 4'h0, 32'h5449_4D31};
        vecs[9]  = '{0, 32'h0C, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{1, 32'h10, 32'h1234_ABCD, 4'b0011, 32'h0};
        vecs[11] = '{0, 32'h10, 32'h0, 4'h0, 32'h0000_ABCD};
        vecs[12] = '{1, 32'h00, 32'h0000_0042, 4'hF, 32'h0};
        vecs[13] = '{0, 32'h100, 32'h0, 4'h0, 32'h0000_0042};
        vecs[14] = '{1, 32'h10, 32'h0, 4'hF, 32'h0};
        for (int i = 0; i < 15; i++) begin
            bus_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
            if (!vecs[i].wr) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Free-running count from 100 with a tick every cycle.
        wr32(32'h10, 32'd0);
        wr32(32'h00, 32'd100);
        wr32(32'h08, 32'd1);
        idle(8);
        bus_xfer(1'b0, 32'h00, 32'd0, 4'd0, rd);
        chk_true("count_range", (rd >= 32'd108) && (rd <= 32'd112), rd);
        chk("count_exact", rd, 32'd111);
        bus_xfer(1'b0, 32'h00, 32'd0, 4'd0, rd2);
        chk_true("count_monotonic", rd2 > rd, rd2);

        // Compare match with clear-on-match and interrupt, prescale 3.
        wr32(32'h08, 32'd0);
        wr32(32'h0C, 32'd1);
        wr32(32'h10, 32'd3);
        wr32(32'h04, 32'd5);
        wr32(32'h00, 32'd0);
        wr32(32'h08, 32'd7);
        idle(21);
        chk("irq_before_match", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq_at_match", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq_after_match", {31'd0, irq}, 32'd1);
        bus_xfer(1'b0, 32'h0C, 32'd0, 4'd0, rd);
        chk("status_match", rd, 32'd1);
        bus_xfer(1'b0, 32'h00, 32'd0, 4'd0, rd);
        chk_true("count_restarted", rd < 32'd3, rd);
        wr32(32'h0C, 32'd1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // COUNT write colliding with a tick.
        wr32(32'h08, 32'd0);
        wr32(32'h10, 32'd0);
        wr32(32'h04, 32'hFFFF_FFF0);
        wr32(32'h08, 32'd1);
        wr32(32'h00, 32'h1234);
        wr32(32'h08, 32'd0);
        bus_xfer(1'b0, 32'h00, 32'd0, 4'd0, rd);
        chk("count_collision", rd, 32'h1238);

        // Status clear colliding with a match.
        wr32(32'h0C, 32'd1);
        wr32(32'h04, 32'd3);
        wr32(32'h08, 32'd1);
        wr32(32'h00, 32'd0);
        wr32(32'h0C, 32'd1);
        wr32(32'h08, 32'd0);
        bus_xfer(1'b0, 32'h0C, 32'd0, 4'd0, rd);
        chk("w1c_collision", rd, 32'd1);
        wr32(32'h0C, 32'd1);

        // mem_valid held long after ready: exactly one pulse.
        pulses = 0;
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h14; bus.mem_wstrb = WSTRB_READ;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 32'd0, 32'd0, 4'd0);
            if (bus.mem_ready) pulses++;
        end
        @(negedge clk);
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 32'd0, 4'd0);
            if (bus.mem_ready) pulses++;
        end
        chk("single_ready", pulses, 32'd1);
        chk("held_rdata", bus.mem_rdata, 32'h5449_4D31);
        m_rdata = 32'h5449_4D31;

        // Reset arriving while a COUNT write is in ACCESS.
        wr32(32'h10, 32'd2);
        wr32(32'h08, 32'd7);
        @(negedge clk);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h00; bus.mem_wdata = 32'd999; bus.mem_wstrb = 4'hF;
        step(1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("reset_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("reset_rdata", bus.mem_rdata, 32'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 32'd0, 4'd0);
            if (bus.mem_ready) pulses++;
        end
        @(negedge clk);
        reset = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_wstrb = WSTRB_READ;
        step(1'b0, 32'd0, 32'd0, 4'd0);
        if (bus.mem_ready) pulses++;
        chk("reset_no_ready", pulses, 32'd0);
        bus_xfer(1'b0, 32'h00, 32'd0, 4'd0, rd);
        chk("reset_count", rd, 32'd0);
        bus_xfer(1'b0, 32'h04, 32'd0, 4'd0, rd);
        chk("reset_compare", rd, 32'hFFFF_FFFF);
        bus_xfer(1'b0, 32'h08, 32'd0, 4'd0, rd);
        chk("reset_ctrl", rd, 32'd0);
        bus_xfer(1'b0, 32'h10, 32'd0, 4'd0, rd);
        chk("reset_prescale", rd, 32'd0);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0:       off = 8'h00;
                1:       off = 8'h04;
                2:       off = 8'h08;
                3:       off = 8'h0C;
                4:       off = 8'h10;
                5:       off = 8'h14;
                6:       off = 8'h18;
                default: off = 8'h3C;
            endcase
            off[1:0] = 2'($urandom_range(0, 3));
            r  = $urandom();
            a  = {r[31:8], off};
            wr = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom();
            s  = wr ? 4'($urandom_range(1, 15)) : WSTRB_READ;
            bus_xfer(wr, a, d, s, rd);
            idle(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic checkOutput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_wstrb = WSTRB_READ;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready0", {31'd0, bus.mem_ready}, 32'd0);
        chk("reset_rdata0", bus.mem_rdata, 32'd0);
        chk("reset_irq0", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
